// File: rtl/gsram_seq_ctrl.sv
// gsram_seq_ctrl: gSRAM LUT load + m2 compute sequencer; ports: start/skip_load/abort in, busy/done/err out, sram_* array side, lut_addr, m2_* valid/ready side
module gsram_seq_ctrl #(
  parameter int ROWS = 10,
  parameter int COLS = 10,
  parameter int DW = 16,
  parameter int M2_TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          skip_load,
  input  logic          abort,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic          sram_we,
  output logic [3:0]    sram_row,
  output logic [3:0]    sram_col,
  output logic          sram_inmuxsel,
  input  logic [DW-1:0] sram_rdata,
  output logic [6:0]    lut_addr,
  output logic          m2_op_valid,
  output logic [DW-1:0] m2_op_data,
  input  logic          m2_op_ready,
  input  logic          m2_res_valid,
  output logic          m2_res_ack
);
  localparam int TW = $clog2(M2_TIMEOUT + 1);
  typedef enum logic [3:0] {IDLE, LOAD, RD, RWAIT, ISSUE, WAITRES, WB, FLUSH1, FLUSH2, DONE} state_t;
  state_t state, state_n;
  logic [3:0] row, col, row_n, col_n, row_a, col_a;
  logic [TW-1:0] tcnt, tcnt_n;
  logic [DW-1:0] op_q, op_n;
  logic [6:0] lut_q, lut_n, lin;
  logic err_n, last;
  assign lin = 7'(row) * 7'(COLS) + 7'(col);
  assign last = row == 4'(ROWS - 1) && col == 4'(COLS - 1);
  assign col_a = col == 4'(COLS - 1) ? 4'd0 : col + 4'd1;
  assign row_a = col == 4'(COLS - 1) ? row + 4'd1 : row;
  always_comb begin
    state_n = state;
    row_n = row;
    col_n = col;
    tcnt_n = tcnt;
    op_n = op_q;
    lut_n = lut_q;
    err_n = err;
    if (abort) state_n = IDLE;
    else case (state)
      IDLE: if (start) begin
        err_n = 1'b0;
        row_n = 4'd0;
        col_n = 4'd0;
        state_n = skip_load ? RD : LOAD;
      end
      LOAD: begin
        lut_n = lin;
        row_n = last ? 4'd0 : row_a;
        col_n = last ? 4'd0 : col_a;
        state_n = last ? RD : LOAD;
      end
      RD: state_n = RWAIT;
      RWAIT: begin
        op_n = sram_rdata;
        state_n = ISSUE;
      end
      ISSUE: begin
        tcnt_n = '0;
        state_n = m2_op_ready ? WAITRES : ISSUE;
      end
      WAITRES: if (m2_res_valid) state_n = WB;
      else if (tcnt == TW'(M2_TIMEOUT - 1)) begin
        err_n = 1'b1;
        state_n = IDLE;
      end else tcnt_n = tcnt + TW'(1);
      WB: begin
        row_n = last ? row : row_a;
        col_n = last ? col : col_a;
        state_n = last ? FLUSH1 : RD;
      end
      FLUSH1: state_n = FLUSH2;
      FLUSH2: state_n = DONE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      row <= '0;
      col <= '0;
      tcnt <= '0;
      op_q <= '0;
      lut_q <= '0;
      err <= 1'b0;
    end else begin
      state <= state_n;
      row <= row_n;
      col <= col_n;
      tcnt <= tcnt_n;
      op_q <= op_n;
      lut_q <= lut_n;
      err <= err_n;
    end
  end
  assign busy = state != IDLE && state != DONE;
  assign done = state == DONE;
  assign sram_we = !rst && !abort && (state == LOAD || state == WB);
  assign sram_row = row;
  assign sram_col = col;
  assign sram_inmuxsel = state == LOAD;
  assign lut_addr = state == LOAD ? lin : lut_q;
  assign m2_op_valid = !rst && !abort && state == ISSUE;
  assign m2_op_data = op_q;
  assign m2_res_ack = !rst && !abort && state == WB;
endmodule

// File: doc/gsram_seq_ctrl.md
Name: gsram_seq_ctrl

Overview:
- Sequencer for the 10x10x16 gSRAM scratch array.
- Phase 1 (LOAD): fills every cell row-major from the LUT (gSRAM input mux = LUT).
- Phase 2 (COMPUTE): per cell, reads the value, hands it to the m2 arithmetic unit over a valid/ready handshake, then writes the m2 result back to the same cell (input mux = m2).
- Signals completion only after the gSRAM row snapshot outputs (mem0..mem9) reflect the final array.

Parameters:
- ROWS, 10, array rows; row index width 4.
- COLS, 10, array columns; column index width 4.
- DW, 16, data width.
- M2_TIMEOUT, 255, maximum cycles waited in WAITRES before error abort.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin sequence; sampled only in IDLE.
- skip_load  in  1  sampled with start; 1 = skip LOAD, go straight to COMPUTE.
- abort  in  1  return to IDLE at next edge from any state.
- busy  out  1  high in every state except IDLE/DONE.
- done  out  1  one-cycle pulse at sequence completion.
- err  out  1  sticky m2 timeout flag; cleared by rst or by an accepted start.
- sram_we  out  1  gSRAM write enable.
- sram_row  out  4  gSRAM row address.
- sram_col  out  4  gSRAM column address.
- sram_inmuxsel  out  1  gSRAM write source: 1 = LUT, 0 = m2 result.
- sram_rdata  in  DW  gSRAM registered read data.
- lut_addr  out  7  LUT index = row*COLS+col; valid in LOAD.
- m2_op_valid  out  1  operand valid to m2.
- m2_op_data  out  DW  operand (registered).
- m2_op_ready  in  1  m2 accepts operand.
- m2_res_valid  in  1  m2 result valid on gSRAM m2result input.
- m2_res_ack  out  1  one-cycle pulse; result consumed (WB cycle).

Behaviour:
- Reset:
  - state=IDLE; row=col=0.
  - All outputs 0.
  - Reset mid-sequence abandons the operation; no further writes.
- IDLE:
  - sram_we=0.
  - If start: clear err, row=col=0; go to COMPUTE_RD if skip_load, else LOAD.
- LOAD:
  - sram_we=1, sram_inmuxsel=1, lut_addr=row*COLS+col.
  - Advance address each cycle: col increments; col wraps 9->0 with row+1.
  - At (9,9): go to RD with row=col=0.
  - Exactly 100 cycles.
- RD: sram_we=0 (read issued); go to RWAIT.
- RWAIT: capture sram_rdata into operand register; go to ISSUE.
- ISSUE:
  - m2_op_valid=1; m2_op_data stable while valid.
  - On m2_op_ready=1 (same cycle): go to WAITRES.
- WAITRES:
  - Wait for m2_res_valid=1, then go to WB.
  - Timeout counter starts at 0 on entry; if it reaches M2_TIMEOUT with no result: err=1, go to IDLE, no write.
- WB:
  - sram_we=1, sram_inmuxsel=0, m2_res_ack=1, same row/col as RD.
  - m2 must hold m2result stable from m2_res_valid through the WB cycle.
  - If cell (9,9): go to FLUSH. Else advance address and go to RD.
- FLUSH: 2 cycles, sram_we=0, so that mem0..mem9 snapshots update; then go to DONE.
- DONE: done=1 for one cycle; go to IDLE.
- Other outputs:
  - sram_inmuxsel=0 outside LOAD.
  - lut_addr holds its last value outside LOAD.
- Timing: minimum 5 cycles per COMPUTE cell. Full run with zero-wait m2 = 100+500+2 busy cycles; done in cycle 603 after the start edge.
- Priority: rst > abort > normal transitions.
  - abort forces sram_we=0 and m2_op_valid=0 combinationally in that cycle.
- start while busy is ignored.
- m2_res_valid outside WAITRES is ignored.

Test Plan:
- Zero-wait m2 (op_ready=1, res_valid=1 tied; m2 = x+1; LUT[i]=i), start -> done pulses in cycle 603; mem[r][c] = r*10+c+1 for all cells; busy is high for exactly 602 cycles.
- skip_load=1, array preloaded with 5 -> no LUT writes (sram_inmuxsel never 1); all cells = 6; done in cycle 503.
- m2_op_ready delayed 3 cycles and res_valid delayed 4 cycles on cell (2,7) -> m2_op_data stable throughout; exactly one write to (2,7); other cells unaffected.
- m2 never returns a result on cell (0,3) -> err=1 after 255 WAITRES cycles, state IDLE, cells (0,3)..(9,9) keep LUT values; next start clears err.
- abort asserted in LOAD at cell (4,4) -> sram_we=0 that cycle; busy=0 next cycle; cells after (4,3) unwritten.
- rst pulsed during WB of cell (5,5), and start pulsed while busy -> after rst all outputs 0 and state IDLE; start while busy causes no restart.
